// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a simple request/response
// handshake. Each accepted request sits in a programmable number of wait
// states, performs its access on one edge, then raises a one-cycle response.
// Sub-word loads are extracted and extended; sub-word stores merge into the
// existing word. Misaligned or illegal-size requests complete with an error
// and leave memory untouched.

module mem_responder #(
   parameter int WAIT_CYCLES = 2,
   parameter int DEPTH_LOG2  = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        busy,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } stateType;

   localparam int DEPTH = 1 << DEPTH_LOG2;

   stateType state;
   stateType nextState;

   logic [3:0]              waitCount;
   logic                    reqWrite;
   logic [DEPTH_LOG2+1:0]   reqAddr;
   logic [31:0]             reqWdata;
   logic [1:0]              reqSize;
   logic                    reqUnsigned;

   logic [31:0]             mem [DEPTH];

   logic [DEPTH_LOG2-1:0]   wordIdx;
   logic [1:0]              byteOff;
   logic [31:0]             memWord;
   logic [7:0]              laneByte;
   logic [15:0]             laneHalf;
   logic                    accessError;
   logic                    accessEdge;
   logic [31:0]             loadData;
   logic [31:0]             storeWord;

   // Address bits above the memory window are deliberately ignored so that
   // the memory wraps around; folding them here keeps them visibly unused.
   logic unusedAddrBits;
   assign unusedAddrBits = ^req_addr[31:DEPTH_LOG2+2];

   // The access happens on the edge that leaves WAIT with an expired counter.
   assign accessEdge = (state == WAIT) && (waitCount == 4'd0);

   // State register; reset returns to IDLE and abandons any request in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic: accept in IDLE, count down in WAIT, always leave RESP.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               nextState = WAIT;
            end
         end
         WAIT: begin
            if (waitCount == 4'd0) begin
               nextState = RESP;
            end
         end
         RESP: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Outputs decoded from state: busy whenever a request is in flight.
   always_comb begin
      busy       = (state != IDLE);
      resp_valid = (state == RESP);
   end

   // Request capture and wait counter; new requests are only taken in IDLE,
   // so anything presented during WAIT or RESP is simply dropped.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         waitCount   <= 4'd0;
         reqWrite    <= 1'b0;
         reqAddr     <= '0;
         reqWdata    <= 32'd0;
         reqSize     <= 2'd0;
         reqUnsigned <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  waitCount   <= 4'(WAIT_CYCLES);
                  reqWrite    <= req_write;
                  reqAddr     <= req_addr[DEPTH_LOG2+1:0];
                  reqWdata    <= req_wdata;
                  reqSize     <= req_size;
                  reqUnsigned <= req_unsigned;
               end
            end
            WAIT: begin
               if (waitCount != 4'd0) begin
                  waitCount <= waitCount - 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Access datapath: alignment check, lane extraction with extension for
   // loads, and read-modify-write merge of the addressed lanes for stores.
   always_comb begin
      wordIdx  = reqAddr[DEPTH_LOG2+1:2];
      byteOff  = reqAddr[1:0];
      memWord  = mem[wordIdx];
      laneByte = memWord[{byteOff, 3'b000} +: 8];
      laneHalf = byteOff[1] ? memWord[31:16] : memWord[15:0];

      accessError = 1'b0;
      case (reqSize)
         2'd0:    accessError = 1'b0;
         2'd1:    accessError = byteOff[0];
         2'd2:    accessError = (byteOff != 2'd0);
         default: accessError = 1'b1;
      endcase

      loadData = memWord;
      case (reqSize)
         2'd0: loadData = reqUnsigned ? {24'd0, laneByte}
                                      : {{24{laneByte[7]}}, laneByte};
         2'd1: loadData = reqUnsigned ? {16'd0, laneHalf}
                                      : {{16{laneHalf[15]}}, laneHalf};
         default: loadData = memWord;
      endcase

      storeWord = memWord;
      case (reqSize)
         2'd0:    storeWord[{byteOff, 3'b000} +: 8] = reqWdata[7:0];
         2'd1:    storeWord[{byteOff[1], 4'b0000} +: 16] = reqWdata[15:0];
         default: storeWord = reqWdata;
      endcase
   end

   // Memory array has no reset so its contents survive a reset pulse; an
   // aborted request never reaches the access edge and so never writes.
   always_ff @(posedge clock) begin
      if (accessEdge && !reset && reqWrite && !accessError) begin
         mem[wordIdx] <= storeWord;
      end
   end

   // Response registers load on the access edge and hold until the next one.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         resp_rdata <= 32'd0;
         resp_error <= 1'b0;
      end else if (accessEdge) begin
         resp_error <= accessError;
         resp_rdata <= (accessError || reqWrite) ? 32'd0 : loadData;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and
// one with none, sharing the request inputs and the reset.

module tb_mem_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;

   logic        aBusy, aValid, aError;
   logic [31:0] aRdata;
   logic        bBusy, bValid, bError;
   logic [31:0] bRdata;

   logic        selB = 1'b0;
   logic        obsBusy, obsValid, obsError;
   logic [31:0] obsRdata;

   int compared = 0;
   int mismatched = 0;
   int respCount;
   int idleCount;
   int pulses;

   mem_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(8)) dutA (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
      .busy(aBusy), .resp_valid(aValid), .resp_rdata(aRdata), .resp_error(aError)
   );

   mem_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(8)) dutB (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
      .busy(bBusy), .resp_valid(bValid), .resp_rdata(bRdata), .resp_error(bError)
   );

   // Observe whichever instance the current step is aimed at.
   assign obsBusy  = selB ? bBusy  : aBusy;
   assign obsValid = selB ? bValid : aValid;
   assign obsError = selB ? bError : aError;
   assign obsRdata = selB ? bRdata : aRdata;

   // Free-running clock, inputs change and outputs are sampled on negedge.
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One request through the selected instance: latency, response values,
   // single-cycle pulse and held response data afterwards.
   task automatic applyStimulus(input string tag, input bit useB, input logic w,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [1:0] sz, input logic u,
                                input logic [31:0] expData, input logic expErr);
      int n;
      int expLat;
      expLat = useB ? 2 : 4;
      @(negedge clock);
      selB = useB;
      req_write = w;
      req_addr = a;
      req_wdata = wd;
      req_size = sz;
      req_unsigned = u;
      req_valid = 1'b1;
      @(negedge clock);
      req_valid = 1'b0;
      checkOutput({tag, " busy after accept"}, 32'(obsBusy), 32'd1);
      n = 1;
      while (obsValid !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      checkOutput({tag, " latency"}, n, expLat);
      checkOutput({tag, " rdata"}, obsRdata, expData);
      checkOutput({tag, " error"}, 32'(obsError), 32'(expErr));
      @(negedge clock);
      checkOutput({tag, " pulse end"}, 32'(obsValid), 32'd0);
      checkOutput({tag, " idle after"}, 32'(obsBusy), 32'd0);
      checkOutput({tag, " rdata held"}, obsRdata, expData);
   endtask

   initial begin
      $display("[TB] start");
      repeat (2) @(negedge clock);
      checkOutput("reset busy", 32'(aBusy), 32'd0);
      checkOutput("reset resp_valid", 32'(aValid), 32'd0);
      checkOutput("reset rdata", aRdata, 32'd0);
      checkOutput("reset error", 32'(aError), 32'd0);
      reset = 1'b0;

      applyStimulus("st word 10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0, 1'b0);
      applyStimulus("ld word 10", 0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
      applyStimulus("st byte 11", 0, 1'b1, 32'h11, 32'h0000007F, 2'd0, 1'b0, 32'h0, 1'b0);
      applyStimulus("ld word merged", 0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'hDEAD7FEF, 1'b0);
      applyStimulus("ld byte s 13", 0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 32'hFFFFFFDE, 1'b0);
      applyStimulus("ld byte u 13", 0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 32'h000000DE, 1'b0);
      applyStimulus("ld half misaligned", 0, 1'b0, 32'h11, 32'h0, 2'd1, 1'b0, 32'h0, 1'b1);
      applyStimulus("st size3", 0, 1'b1, 32'h10, 32'hFFFFFFFF, 2'd3, 1'b0, 32'h0, 1'b1);
      applyStimulus("ld after size3", 0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'hDEAD7FEF, 1'b0);
      applyStimulus("ld half s 12", 0, 1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 32'hFFFFDEAD, 1'b0);
      applyStimulus("ld half u 10", 0, 1'b0, 32'h10, 32'h0, 2'd1, 1'b1, 32'h00007FEF, 1'b0);
      applyStimulus("st half 12", 0, 1'b1, 32'h12, 32'hAAAA0102, 2'd1, 1'b0, 32'h0, 1'b0);
      applyStimulus("ld after half st", 0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b1, 32'h01027FEF, 1'b0);
      applyStimulus("st word misaligned", 0, 1'b1, 32'h12, 32'h55555555, 2'd2, 1'b0, 32'h0, 1'b1);
      applyStimulus("ld after misaligned", 0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'h01027FEF, 1'b0);
      applyStimulus("st word 20", 0, 1'b1, 32'h20, 32'hCAFEF00D, 2'd2, 1'b0, 32'h0, 1'b0);

      // Request held high: exactly one response and one idle cycle per 5.
      @(negedge clock);
      selB = 1'b0;
      req_write = 1'b0;
      req_addr = 32'h10;
      req_size = 2'd2;
      req_unsigned = 1'b0;
      req_valid = 1'b1;
      respCount = 0;
      idleCount = 0;
      repeat (15) begin
         @(negedge clock);
         if (aValid) respCount++;
         if (!aBusy) idleCount++;
      end
      req_valid = 1'b0;
      checkOutput("held responses", respCount, 3);
      checkOutput("held idle cycles", idleCount, 3);
      checkOutput("held rdata", aRdata, 32'h01027FEF);

      // Reset one cycle after accepting a store aborts it.
      @(negedge clock);
      req_write = 1'b1;
      req_addr = 32'h20;
      req_wdata = 32'h12345678;
      req_size = 2'd2;
      req_valid = 1'b1;
      @(posedge clock);
      #1 req_valid = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
      #1;
      checkOutput("abort busy", 32'(aBusy), 32'd0);
      checkOutput("abort resp_valid", 32'(aValid), 32'd0);
      pulses = 0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (6) begin
         @(negedge clock);
         if (aValid) pulses++;
      end
      checkOutput("abort no pulse", pulses, 0);
      applyStimulus("ld after abort", 0, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0);

      // Zero wait states and address wrap-around on the second instance.
      applyStimulus("w0 st 400", 1, 1'b1, 32'h400, 32'hA5A5A5A5, 2'd2, 1'b0, 32'h0, 1'b0);
      applyStimulus("w0 ld 0 wrap", 1, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 32'hA5A5A5A5, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, wait states inserted before each access (0..15).
REQ-002 Parameter DEPTH_LOG2, default 8, internal memory holds 2^DEPTH_LOG2 32-bit words.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 req_valid  input  1  request present this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-aligned.
REQ-009 req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 = illegal.
REQ-010 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 busy  output  1  request in flight; requests ignored while high.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  32  load result, valid with resp_valid.
REQ-014 resp_error  output  1  misaligned or illegal-size request, valid with resp_valid.

Function
REQ-015 FSM states IDLE, WAIT, RESP; 2-bit state register plus 4-bit wait counter.
REQ-016 IDLE: on edge with req_valid=1, capture write/addr/wdata/size/unsigned, load counter with WAIT_CYCLES, go to WAIT; otherwise stay IDLE.
REQ-017 WAIT: counter nonzero -> decrement, stay; counter zero -> perform access on that edge, go to RESP.
REQ-018 RESP: resp_valid=1 for exactly this cycle; next edge -> IDLE unconditionally.
REQ-019 Latency: request accepted at edge E0 -> access at edge E0+WAIT_CYCLES+1 -> resp_valid high in the following cycle only.
REQ-020 busy = 1 in WAIT and RESP, 0 in IDLE; req_valid in WAIT/RESP is dropped, not queued.
REQ-021 Word index = addr[DEPTH_LOG2+1:2]; higher address bits ignored (wrap-around).
REQ-022 Alignment: halfword needs addr[0]=0, word needs addr[1:0]=0; size 3 always illegal.
REQ-023 Error request: no memory write, resp_rdata=0, resp_error=1; same latency as legal request.
REQ-024 Store byte: write wdata[7:0] to lane addr[1:0]; halfword: wdata[15:0] to lanes addr[1]*2..+1; word: all lanes; other lanes unchanged.
REQ-025 Load: extract lane(s) per size/offset, extend to 32 bits per req_unsigned; word ignores req_unsigned.
REQ-026 Store response: resp_rdata=0, resp_error=0.
REQ-027 resp_rdata and resp_error hold their value until the next access; only sampled when resp_valid=1.
REQ-028 Load in the cycle immediately after a store to the same address returns the newly stored data.

Reset
REQ-029 On reset: state=IDLE, counter=0, busy=0, resp_valid=0, resp_rdata=0, resp_error=0.
REQ-030 Reset while in WAIT before access edge aborts the request: no memory write, no response.
REQ-031 Memory contents are not cleared by reset.

Verification
REQ-032 WAIT_CYCLES=2: store word 0xDEADBEEF at 0x10 accepted at E0 -> resp_valid only in cycle after E3, resp_error=0; load word 0x10 -> resp_rdata=0xDEADBEEF.
REQ-033 Store byte 0x7F at 0x11 over 0xDEADBEEF -> load word 0x10 = 0xDEAD7FEF; load byte signed 0x13 = 0xFFFFFFDE, unsigned = 0x000000DE.
REQ-034 Load halfword at 0x11 -> resp_error=1, resp_rdata=0; req_size=3 store -> resp_error=1, memory unchanged.
REQ-035 req_valid held high continuously -> one response per WAIT_CYCLES+3 cycles, busy high between, no requests double-accepted.
REQ-036 Assert reset one cycle after accepting store 0x12345678 to 0x20 -> busy=0, resp_valid never pulses, subsequent load 0x20 returns prior contents.
REQ-037 WAIT_CYCLES=0, DEPTH_LOG2=8: store 0xA5A5A5A5 at 0x400 -> load at 0x0 returns 0xA5A5A5A5 (wrap-around), response one cycle after access edge E1.
